// File: rtl/lsu_arb_pkg.sv
// Shared types and helpers for the LSU bus arbiter: FSM state encoding,
// latched request record, peripheral "unmapped" read value and address decode.
package lsu_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DMEM_REQ = 3'd1,
    ST_DMEM_RSP = 3'd2,
    ST_PER_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } arb_state_e;

  // Value a peripheral returns for an address it does not decode.
  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  // Peripheral space is any address with a non-zero nibble in bits [15:12].
  function automatic logic is_periph(input logic [31:0] addr);
    logic [31:0] sel_mask;
    sel_mask = 32'h0000_F000;
    return ((addr & sel_mask) != 32'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that was not granted last wins. The pointer moves on every grant
// and resets so that m0 is favoured first.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;   // 1: m1 was granted last (so m0 wins a tie)
  logic last_d;
  logic [1:0] gnt_s;

  // Pick the winner for this cycle and the next pointer value.
  always_comb begin
    gnt_s  = 2'b00;
    last_d = last_q;
    if (en) begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = last_q ? 2'b01 : 2'b10;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
    if (gnt_s != 2'b00) begin
      last_d = gnt_s[1];
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset favours m0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/lsu_bus_arbiter.sv
// Load/store path arbiter between the core LSU (m0) and the debug host (m1).
// One granted access at a time is sequenced to the sync-read data memory or
// the ack-based peripheral port; each access returns one registered response.
// Reads acked by a peripheral with the SENTINEL value are retried in data memory.
// Optional feature macro: LSU_ARB_TIMEOUT_EN (peripheral ack timeout with err).
module lsu_bus_arbiter #(
  parameter logic [31:0] SENTINEL = lsu_arb_pkg::SENTINEL
`ifdef LSU_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 32'd16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        dmem_en,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_rdata,
  output logic        per_req,
  output logic        per_we,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_wmask,
  input  logic        per_ack,
  input  logic [31:0] per_rdata
);

  import lsu_arb_pkg::*;

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;       // 0: m0 owns the access, 1: m1
  req_t        req_q, req_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        dmem_en_q, dmem_en_d;
  logic        dmem_we_q, dmem_we_d;
  logic        per_req_q, per_req_d;
  logic        per_we_q, per_we_d;
`ifdef LSU_ARB_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
`endif

  logic        arb_en_s;
  logic [1:0]  gnt_s;
  req_t        win_s;
  logic        rsp_fire_s, rsp_load_s, rsp_err_s;
  logic [31:0] rsp_data_s;

  // Grants are only issued while idle and never in a reset cycle.
  assign arb_en_s = (state_q == ST_IDLE) && !rst;

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .en  (arb_en_s),
    .req ({m1_req, m0_req}),
    .gnt (gnt_s)
  );

  // Select the winning requester's fields for latching.
  always_comb begin
    if (gnt_s[1]) begin
      win_s = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, wmask: m1_wmask};
    end else begin
      win_s = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, wmask: m0_wmask};
    end
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    dmem_en_d  = 1'b0;
    dmem_we_d  = 1'b0;
    per_req_d  = per_req_q;
    per_we_d   = per_we_q;
    rsp_fire_s = 1'b0;
    rsp_load_s = 1'b0;
    rsp_err_s  = 1'b0;
    rsp_data_s = 32'd0;
`ifdef LSU_ARB_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          owner_d = gnt_s[1];
          req_d   = win_s;
          if (is_periph(win_s.addr)) begin
            state_d   = ST_PER_WAIT;
            per_req_d = 1'b1;
            per_we_d  = win_s.we;
`ifdef LSU_ARB_TIMEOUT_EN
            to_cnt_d  = 32'd0;
`endif
          end else begin
            state_d   = ST_DMEM_REQ;
            dmem_en_d = 1'b1;
            dmem_we_d = win_s.we;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DMEM_REQ: begin
        state_d = ST_DMEM_RSP;
      end
      ST_DMEM_RSP: begin
        state_d    = ST_RESP;
        rsp_fire_s = 1'b1;
        rsp_load_s = !req_q.we;
        rsp_data_s = dmem_rdata;
      end
      ST_PER_WAIT: begin
        if (per_ack) begin
          per_req_d = 1'b0;
          per_we_d  = 1'b0;
          if (!req_q.we && (per_rdata == SENTINEL)) begin
            // Unmapped in peripheral space: retry the same read in data memory.
            state_d   = ST_DMEM_REQ;
            dmem_en_d = 1'b1;
            dmem_we_d = 1'b0;
          end else begin
            state_d    = ST_RESP;
            rsp_fire_s = 1'b1;
            rsp_load_s = !req_q.we;
            rsp_data_s = per_rdata;
          end
        end
`ifdef LSU_ARB_TIMEOUT_EN
        else if (to_cnt_q == (TIMEOUT_CYCLES - 32'd1)) begin
          per_req_d  = 1'b0;
          per_we_d   = 1'b0;
          state_d    = ST_RESP;
          rsp_fire_s = 1'b1;
          rsp_err_s  = 1'b1;
          rsp_load_s = !req_q.we;
          rsp_data_s = SENTINEL;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
`else
        else begin
          state_d = ST_PER_WAIT;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Route the response pulse and read data to the owning requester only.
  always_comb begin
    rvalid_d = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (rsp_fire_s) begin
      rvalid_d[owner_q] = 1'b1;
      err_d[owner_q]    = rsp_err_s;
    end else begin
      rvalid_d = 2'b00;
    end
    if (rsp_fire_s && rsp_load_s) begin
      if (owner_q) begin
        rdata1_d = rsp_data_s;
      end else begin
        rdata0_d = rsp_data_s;
      end
    end else begin
      rdata0_d = rdata0_q;
    end
  end

  // State and registered outputs; reset discards any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      req_q     <= '0;
      rvalid_q  <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      dmem_en_q <= 1'b0;
      dmem_we_q <= 1'b0;
      per_req_q <= 1'b0;
      per_we_q  <= 1'b0;
`ifdef LSU_ARB_TIMEOUT_EN
      to_cnt_q  <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      req_q     <= req_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      dmem_en_q <= dmem_en_d;
      dmem_we_q <= dmem_we_d;
      per_req_q <= per_req_d;
      per_we_q  <= per_we_d;
`ifdef LSU_ARB_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign m0_gnt     = gnt_s[0];
  assign m1_gnt     = gnt_s[1];
  assign m0_rvalid  = rvalid_q[0];
  assign m1_rvalid  = rvalid_q[1];
  assign m0_err     = err_q[0];
  assign m1_err     = err_q[1];
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;
  assign dmem_en    = dmem_en_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = req_q.addr;
  assign dmem_wdata = req_q.wdata;
  assign dmem_wmask = req_q.wmask;
  assign per_req    = per_req_q;
  assign per_we     = per_we_q;
  assign per_addr   = req_q.addr;
  assign per_wdata  = req_q.wdata;
  assign per_wmask  = req_q.wmask;

endmodule
